// File: rtl/typing_pkg.sv
// typing_pkg: shared sizes and the letter slot record for the falling-letter pool
package typing_pkg;
    localparam int NSLOTS  = 8;
    localparam int X_LIMIT = 440;
    localparam int CH_W    = 8;
    localparam int X_W     = 9;
    localparam int Y_W     = 10;
    localparam int SPD_W   = 3;

    typedef struct packed {
        logic             valid;
        logic [CH_W-1:0]  ch;
        logic [SPD_W-1:0] speed;
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
    } slot_t;
endpackage

// File: rtl/slot_picker.sv
// slot_picker: picks the masked slot with the largest x, lowest index on a tie
module slot_picker
    import typing_pkg::*;
#(
    parameter int N  = NSLOTS,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]          mask,
    input  logic [N-1:0][X_W-1:0] xs,
    output logic [IW-1:0]         idx,
    output logic                  found
);
    // strict compare keeps the earliest index when x values are equal
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && (!found || xs[i] > xs[idx])) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/letter_pool.sv
// letter_pool: slot pool of falling letters with key matching, per-frame advance and scoring
module letter_pool
    import typing_pkg::*;
#(
    parameter int NSLOTS  = typing_pkg::NSLOTS,
    parameter int X_LIMIT = typing_pkg::X_LIMIT,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spawn,
    input  logic [7:0]                spawn_ch,
    input  logic [2:0]                spawn_speed,
    input  logic [8:0]                spawn_x,
    input  logic [9:0]                spawn_y,
    input  logic                      frame_tick,
    input  logic                      key_valid,
    input  logic [7:0]                key_code,
    input  logic [$clog2(NSLOTS)-1:0] rd_slot,
    output logic                      rd_valid,
    output logic [7:0]                rd_ch,
    output logic [8:0]                rd_x,
    output logic [9:0]                rd_y,
    output logic                      hit,
    output logic                      wrong,
    output logic                      miss,
    output logic                      overflow,
    output logic                      full,
    output logic [CNT_W-1:0]          score,
    output logic [CNT_W-1:0]          misses
);
    localparam int IW = $clog2(NSLOTS);
    localparam int CW = $clog2(NSLOTS + 1);

    slot_t [NSLOTS-1:0]          slots_q, slots_d;
    logic                        hit_q, hit_d, wrong_q, wrong_d, miss_q, miss_d;
    logic                        overflow_q, overflow_d, full_q, full_d;
    logic [CNT_W-1:0]            score_q, score_d, misses_q, misses_d;
    logic [NSLOTS-1:0]           valid_v, match_v;
    logic [NSLOTS-1:0][X_W-1:0]  xs;
    logic [IW-1:0]               win_idx, free_idx;
    logic                        win_found, free_found;
    logic [CW-1:0]               miss_cnt;
    logic [X_W:0]                nx;
    logic [CNT_W:0]              miss_sum;

    // per-slot views feeding the key-match and free-slot searches
    always_comb begin
        for (int i = 0; i < NSLOTS; i++) begin
            valid_v[i] = slots_q[i].valid;
            match_v[i] = slots_q[i].valid && slots_q[i].ch == key_code;
            xs[i]      = slots_q[i].x;
        end
    end

    slot_picker #(.N(NSLOTS), .IW(IW)) u_win (
        .mask(match_v), .xs(xs), .idx(win_idx), .found(win_found)
    );

    // all x equal turns the picker into a lowest-free-index search
    slot_picker #(.N(NSLOTS), .IW(IW)) u_free (
        .mask(~valid_v), .xs('0), .idx(free_idx), .found(free_found)
    );

    // key retires the winner, tick advances the rest, spawn fills a slot free at cycle start
    always_comb begin
        slots_d    = slots_q;
        hit_d      = 1'b0;
        wrong_d    = 1'b0;
        overflow_d = 1'b0;
        score_d    = score_q;
        miss_cnt   = '0;
        nx         = '0;
        if (key_valid && win_found) begin
            slots_d[win_idx].valid = 1'b0;
            hit_d   = 1'b1;
            score_d = (&score_q) ? score_q : score_q + CNT_W'(1);
        end else if (key_valid) begin
            wrong_d = 1'b1;
        end
        if (frame_tick) begin
            for (int i = 0; i < NSLOTS; i++) begin
                if (slots_q[i].valid && !(key_valid && win_found && win_idx == IW'(i))) begin
                    nx = {1'b0, slots_q[i].x} + (X_W+1)'(slots_q[i].speed);
                    if (nx >= (X_W+1)'(X_LIMIT)) begin
                        slots_d[i].valid = 1'b0;
                        miss_cnt = miss_cnt + CW'(1);
                    end else begin
                        slots_d[i].x = nx[X_W-1:0];
                    end
                end
            end
        end
        if (spawn && free_found) begin
            slots_d[free_idx] = '{valid: 1'b1, ch: spawn_ch, speed: spawn_speed, x: spawn_x, y: spawn_y};
        end else if (spawn) begin
            overflow_d = 1'b1;
        end
        miss_sum = {1'b0, misses_q} + (CNT_W+1)'(miss_cnt);
        misses_d = miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];
        miss_d   = miss_cnt != '0;
        full_d   = 1'b1;
        for (int i = 0; i < NSLOTS; i++) begin
            full_d = full_d & slots_d[i].valid;
        end
    end

    // state and pulse registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slots_q    <= '0;
            hit_q      <= 1'b0;
            wrong_q    <= 1'b0;
            miss_q     <= 1'b0;
            overflow_q <= 1'b0;
            full_q     <= 1'b0;
            score_q    <= '0;
            misses_q   <= '0;
        end else begin
            slots_q    <= slots_d;
            hit_q      <= hit_d;
            wrong_q    <= wrong_d;
            miss_q     <= miss_d;
            overflow_q <= overflow_d;
            full_q     <= full_d;
            score_q    <= score_d;
            misses_q   <= misses_d;
        end
    end

    assign rd_valid = slots_q[rd_slot].valid;
    assign rd_ch    = slots_q[rd_slot].ch;
    assign rd_x     = slots_q[rd_slot].x;
    assign rd_y     = slots_q[rd_slot].y;
    assign hit      = hit_q;
    assign wrong    = wrong_q;
    assign miss     = miss_q;
    assign overflow = overflow_q;
    assign full     = full_q;
    assign score    = score_q;
    assign misses   = misses_q;
endmodule

// File: tb/tb_letter_pool.sv
// tb_letter_pool: directed plan plus random traffic checked against a behavioural pool model
module tb_letter_pool;
    localparam int NS   = 8;
    localparam int XL   = 440;
    localparam int CMAX = 65535;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spawn = 1'b0;
    logic [7:0] spawn_ch = '0;
    logic [2:0] spawn_speed = '0;
    logic [8:0] spawn_x = '0;
    logic [9:0] spawn_y = '0;
    logic       frame_tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = '0;
    logic [2:0] rd_slot = '0;
    logic       rd_valid, hit, wrong, miss, overflow, full;
    logic [7:0] rd_ch;
    logic [8:0] rd_x;
    logic [9:0] rd_y;
    logic [15:0] score, misses;

    always #10 clk = ~clk;

    letter_pool #(.NSLOTS(NS), .X_LIMIT(XL), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .spawn(spawn), .spawn_ch(spawn_ch),
        .spawn_speed(spawn_speed), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .frame_tick(frame_tick), .key_valid(key_valid), .key_code(key_code),
        .rd_slot(rd_slot), .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_x(rd_x),
        .rd_y(rd_y), .hit(hit), .wrong(wrong), .miss(miss), .overflow(overflow),
        .full(full), .score(score), .misses(misses)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int mv[NS], mch[NS], msp[NS], mx[NS], my[NS];
    int mscore = 0, mmiss = 0;
    int ehit = 0, ewrong = 0, emiss = 0, eovf = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model: applies one cycle of the pool rules to the current inputs
    task automatic model_step();
        int v0[NS];
        int w, best, cnt, nx, f;
        v0 = mv;
        ehit = 0; ewrong = 0; emiss = 0; eovf = 0;
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                mv[i] = 0; mch[i] = 0; msp[i] = 0; mx[i] = 0; my[i] = 0;
            end
            mscore = 0; mmiss = 0;
            return;
        end
        w = -1;
        if (key_valid) begin
            best = -1;
            for (int i = 0; i < NS; i++)
                if (v0[i] != 0 && mch[i] == int'(key_code) && mx[i] > best) best = mx[i];
            for (int i = 0; i < NS; i++)
                if (w < 0 && v0[i] != 0 && mch[i] == int'(key_code) && mx[i] == best) w = i;
            if (w >= 0) begin
                mv[w] = 0;
                ehit = 1;
                mscore = (mscore + 1 > CMAX) ? CMAX : mscore + 1;
            end else begin
                ewrong = 1;
            end
        end
        cnt = 0;
        if (frame_tick) begin
            for (int i = 0; i < NS; i++) begin
                if (v0[i] != 0 && i != w) begin
                    nx = mx[i] + msp[i];
                    if (nx >= XL) begin
                        mv[i] = 0;
                        cnt++;
                    end else begin
                        mx[i] = nx;
                    end
                end
            end
        end
        mmiss = (mmiss + cnt > CMAX) ? CMAX : mmiss + cnt;
        emiss = (cnt > 0) ? 1 : 0;
        if (spawn) begin
            f = -1;
            for (int i = 0; i < NS; i++) if (f < 0 && v0[i] == 0) f = i;
            if (f >= 0) begin
                mv[f] = 1; mch[f] = int'(spawn_ch); msp[f] = int'(spawn_speed);
                mx[f] = int'(spawn_x); my[f] = int'(spawn_y);
            end else begin
                eovf = 1;
            end
        end
    endtask

    task automatic check_all();
        int efull;
        efull = 1;
        for (int i = 0; i < NS; i++) if (mv[i] == 0) efull = 0;
        chk("hit", 32'(hit), 32'(ehit));
        chk("wrong", 32'(wrong), 32'(ewrong));
        chk("miss", 32'(miss), 32'(emiss));
        chk("overflow", 32'(overflow), 32'(eovf));
        chk("full", 32'(full), 32'(efull));
        chk("score", 32'(score), 32'(mscore));
        chk("misses", 32'(misses), 32'(mmiss));
        for (int i = 0; i < NS; i++) begin
            rd_slot = 3'(i);
            #1;
            chk($sformatf("rd_valid[%0d]", i), 32'(rd_valid), 32'(mv[i]));
            chk($sformatf("rd_ch[%0d]", i), 32'(rd_ch), 32'(mch[i]));
            chk($sformatf("rd_x[%0d]", i), 32'(rd_x), 32'(mx[i]));
            chk($sformatf("rd_y[%0d]", i), 32'(rd_y), 32'(my[i]));
        end
    endtask

    task automatic cyc(input bit sp, input int c, input int s, input int x, input int y,
                       input bit tk, input bit kv, input int kc);
        spawn = sp; spawn_ch = 8'(c); spawn_speed = 3'(s); spawn_x = 9'(x); spawn_y = 10'(y);
        frame_tick = tk; key_valid = kv; key_code = 8'(kc);
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            mv[i] = 0; mch[i] = 0; msp[i] = 0; mx[i] = 0; my[i] = 0;
        end
        @(negedge clk);
        do_reset();
        // plan 1 and 2: single letter, five ticks, then a letter right at the floor
        cyc(1, 65, 2, 0, 37, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        rd_slot = 3'd0;
        #1;
        chk("plan2_x10", 32'(rd_x), 32'd10);
        cyc(1, 90, 2, 438, 5, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("plan2_misses", 32'(misses), 32'd1);
        idle();
        // plan 3: two equal chars, the lower one (larger x) is hit; unknown key is wrong
        do_reset();
        cyc(1, 66, 1, 0, 10, 0, 0, 0);
        cyc(1, 66, 1, 100, 20, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 66);
        chk("plan3_hit", 32'(hit), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 1, 67);
        chk("plan3_wrong", 32'(wrong), 32'd1);
        // plan 4: fill the pool, then overflow
        do_reset();
        for (int k = 0; k < NS; k++) cyc(1, 70 + k, 1, k * 10, k, 0, 0, 0);
        chk("plan4_full", 32'(full), 32'd1);
        cyc(1, 99, 3, 7, 7, 0, 0, 0);
        chk("plan4_ovf", 32'(overflow), 32'd1);
        // plan 5: key wins over a same-cycle miss; spawn while full with a slot freeing
        do_reset();
        cyc(1, 65, 3, 438, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 65);
        chk("plan5_nomiss", 32'(miss), 32'd0);
        for (int k = 0; k < NS; k++) cyc(1, 80, 3, (k == 2) ? 438 : k, k, 0, 0, 0);
        cyc(1, 81, 1, 0, 0, 1, 0, 0);
        chk("plan5_ovf", 32'(overflow), 32'd1);
        // plan 6: reset mid-game with letters and score
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1, 67, 1, k, k, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 1, 67);
        chk("plan6_score3", 32'(score), 32'd3);
        rst_n = 1'b0;
        cyc(1, 67, 1, 0, 0, 1, 1, 67);
        rst_n = 1'b1;
        chk("plan6_score0", 32'(score), 32'd0);
        cyc(1, 68, 1, 0, 0, 1, 1, 67);
        // random traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            cyc($urandom_range(0, 1) == 1,
                65 + $urandom_range(0, 3),
                $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(400, 445) : $urandom_range(0, 200),
                $urandom_range(0, 639),
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0,
                65 + $urandom_range(0, 4));
        end
        rst_n = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
